// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the TX FCS-append FSM state type.
// Also used by the RX FCS checker.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
    localparam int          ETH_MIN_LEN     = 60;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAD,
        ST_FCS
    } tx_state_t;

endpackage

// File: rtl/crc32_byte_upd.sv
// Combinational reflected CRC-32 update for one byte, bits taken LSB-first.
// Shared between the TX append and RX check paths.
module crc32_byte_upd
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (crc_next[0] ^ data[i])
                crc_next = (crc_next >> 1) ^ CRC32_POLY_REFL;
            else
                crc_next = crc_next >> 1;
        end
    end

endmodule

// File: rtl/eth_tx_fcs_append.sv
// Appends the Ethernet FCS (complemented reflected CRC-32, LSB first) to each frame.
// Define ETH_TX_PAD_EN to zero-pad short frames to MIN_LEN bytes before the FCS.
module eth_tx_fcs_append
    import eth_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int CNT_W   = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy
);

`ifdef ETH_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_LEN);

    tx_state_t        state;
    logic [31:0]      crc;
    logic [31:0]      crc_nxt;
    logic [31:0]      fcs_word;
    logic [7:0]       upd_byte;
    logic [7:0]       fcs_byte;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic [1:0]       fcs_idx;
    logic             out_en;
    logic             is_short;

    // The output register may take a new byte when empty or being drained.
    assign out_en    = !m_valid || m_ready;
    assign s_ready   = !rst && ((state == ST_IDLE) || (state == ST_DATA)) && out_en;
    assign busy      = (state != ST_IDLE);

    assign upd_byte  = (state == ST_PAD) ? 8'h00 : s_data;
    assign fcs_word  = ~crc;
    assign fcs_byte  = 8'(fcs_word >> {fcs_idx, 3'b000});

    // Counter saturates; it only steers padding, so the CRC is unaffected.
    assign count_inc = (count == '1) ? count : count + 1'b1;
    assign is_short  = PAD_EN && (count_inc < MIN_CNT);

    crc32_byte_upd u_crc (
        .crc      (crc),
        .data     (upd_byte),
        .crc_next (crc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            crc     <= CRC32_INIT;
            count   <= '0;
            fcs_idx <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (out_en) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DATA: begin
                    if (s_valid) begin
                        m_data  <= s_data;
                        m_valid <= 1'b1;
                        crc     <= crc_nxt;
                        count   <= count_inc;
                        if (s_last)
                            state <= is_short ? ST_PAD : ST_FCS;
                        else
                            state <= ST_DATA;
                    end
                end
                ST_PAD: begin
                    m_data  <= '0;
                    m_valid <= 1'b1;
                    crc     <= crc_nxt;
                    count   <= count_inc;
                    if (count_inc >= MIN_CNT)
                        state <= ST_FCS;
                end
                ST_FCS: begin
                    m_data  <= fcs_byte;
                    m_valid <= 1'b1;
                    fcs_idx <= fcs_idx + 2'd1;
                    if (fcs_idx == 2'd3) begin
                        m_last <= 1'b1;
                        state  <= ST_IDLE;
                        crc    <= CRC32_INIT;
                        count  <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_fcs_append.sv
// Directed/random bench for eth_tx_fcs_append against a queue-based frame model.
// Pad expectations follow ETH_TX_PAD_EN as seen by this compile.
module tb_eth_tx_fcs_append;

`ifdef ETH_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam int MIN_LEN = 60;
    localparam int LIMIT   = 6000;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned stall_pct = 0;
    int unsigned frames_done = 0;
    int unsigned cyc = 0;
    bq_t         got;
    bq_t         exp_b;
    logic        gotl[$];
    logic        exp_l[$];
    int unsigned xfer_cyc[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_last;

    eth_tx_fcs_append #(.MIN_LEN(MIN_LEN), .CNT_W(12)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: samples at negedge, records handshakes and checks stall stability.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", m_valid, 1'b1);
                check("stall_data", m_data, prev_data);
                check("stall_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                gotl.push_back(m_last);
                xfer_cyc.push_back(cyc);
                if (m_last) frames_done++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    function automatic logic [31:0] crc_raw(input bq_t q);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    // Expected wire image: payload, zero pad (if enabled), ~crc LSB first.
    task automatic add_frame(input bq_t p, input bit with_fcs);
        bq_t         e;
        logic [31:0] f;
        e = p;
        if (with_fcs && PAD_EN)
            while (e.size() < MIN_LEN) e.push_back(8'h00);
        foreach (e[i]) begin
            exp_b.push_back(e[i]);
            exp_l.push_back(1'b0);
        end
        if (with_fcs) begin
            f = ~crc_raw(e);
            for (int k = 0; k < 4; k++) begin
                exp_b.push_back(f[8*k +: 8]);
                exp_l.push_back(k == 3);
            end
        end
    endtask

    task automatic compare_all(input string tag);
        int unsigned n;
        check({tag, "_len"}, got.size(), exp_b.size());
        n = (got.size() < exp_b.size()) ? got.size() : exp_b.size();
        for (int unsigned i = 0; i < n; i++) begin
            check($sformatf("%s_byte[%0d]", tag, i), got[i], exp_b[i]);
            check($sformatf("%s_last[%0d]", tag, i), gotl[i], exp_l[i]);
        end
        got.delete(); gotl.delete(); exp_b.delete(); exp_l.delete(); xfer_cyc.delete();
        frames_done = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        m_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
    endtask

    task automatic send_frame(input bq_t q, input bit with_last);
        int unsigned i = 0;
        int unsigned waits = 0;
        logic        hs;
        s_valid = 1'b1;
        s_data  = q[0];
        s_last  = with_last && (q.size() == 1);
        while (i < q.size() && waits <= 1000) begin
            @(negedge clk);
            hs = s_ready;
            cycle();
            if (hs) begin
                i++;
                waits = 0;
                if (i < q.size()) begin
                    s_data = q[i];
                    s_last = with_last && (i == q.size() - 1);
                end
            end else begin
                waits++;
            end
        end
        check("accept_timeout", (waits > 1000), 1'b0);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_frames(input int unsigned n);
        int unsigned k = 0;
        while (frames_done < n && k < LIMIT) begin
            cycle();
            k++;
        end
        check("frames_done", frames_done, n);
        repeat (2) cycle();
    endtask

    function automatic bq_t rand_frame(input int unsigned n);
        bq_t q;
        for (int unsigned i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
        return q;
    endfunction

    task automatic run_ascii(input string tag);
        bq_t        p;
        logic [7:0] kfcs[4];
        p    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        kfcs = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        add_frame(p, 1'b1);
        send_frame(p, 1'b1);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_sready_tail"}, s_ready, 1'b0);
        wait_frames(1);
        if (!PAD_EN)
            for (int unsigned k = 0; k < 4; k++)
                check($sformatf("%s_known_fcs[%0d]", tag, k), got[9+k], kfcs[k]);
        compare_all(tag);
    endtask

    initial begin
        bq_t         pa;
        bq_t         pb;
        int unsigned idx;

        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        rst = 1'b0;
        cycle();
        check("idle_s_ready", s_ready, 1'b1);
        check("idle_busy", busy, 1'b0);

        run_ascii("ascii");

        pa = '{8'h00};
        add_frame(pa, 1'b1);
        send_frame(pa, 1'b1);
        wait_frames(1);
        check("one_byte_residue", crc_raw(got), 32'hDEBB20E3);
        compare_all("one_byte");

        pa = rand_frame(60);
        add_frame(pa, 1'b1);
        send_frame(pa, 1'b1);
        wait_frames(1);
        check("min_len_residue", crc_raw(got), 32'hDEBB20E3);
        compare_all("min_len");

        stall_pct = 50;
        pa = rand_frame(100);
        add_frame(pa, 1'b1);
        send_frame(pa, 1'b1);
        wait_frames(1);
        stall_pct = 0;
        cycle();
        compare_all("stall100");

        pa = rand_frame(5);
        add_frame(pa, 1'b0);
        send_frame(pa, 1'b0);
        cycle(); cycle();
        rst = 1'b1;
        #1;
        check("mid_rst_m_valid", m_valid, 1'b0);
        check("mid_rst_m_data", m_data, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_s_ready", s_ready, 1'b0);
        cycle(); cycle();
        rst = 1'b0;
        repeat (10) cycle();
        check("mid_rst_no_fcs", frames_done, 0);
        compare_all("mid_rst_partial");
        run_ascii("after_rst");

        pa = rand_frame(20);
        pb = rand_frame(7);
        add_frame(pa, 1'b1);
        idx = exp_b.size();
        add_frame(pb, 1'b1);
        send_frame(pa, 1'b1);
        send_frame(pb, 1'b1);
        wait_frames(2);
        check("b2b_gap", xfer_cyc[idx], xfer_cyc[idx-1] + 1);
        compare_all("b2b");

        pa = rand_frame(4100);
        add_frame(pa, 1'b1);
        send_frame(pa, 1'b1);
        wait_frames(1);
        check("sat_residue", crc_raw(got), 32'hDEBB20E3);
        compare_all("sat");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
